// File: rtl/ddr_cmd_sched.sv
// DDR5 read/write command scheduler: per-bank open-row tracking,
// row-hit-first arbitration with a starvation limit, range error reporting.
module ddr_cmd_sched #(
    parameter int ADDR_W     = 32,
    parameter int COL_W      = 10,
    parameter int BA_W       = 2,
    parameter int BG_W       = 3,
    parameter int ROW_W      = 16,
    parameter int T_PRE      = 5,
    parameter int T_ACT      = 5,
    parameter int CL         = 20,
    parameter int BL         = 2,
    parameter int STARVE_MAX = 8,
    parameter logic [ADDR_W-1:0] R0_BASE  = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] R0_LIMIT = 32'h0000_8000,
    parameter logic [ADDR_W-1:0] R1_BASE  = 32'h0010_0000,
    parameter logic [ADDR_W-1:0] R1_LIMIT = 32'h0010_8000
) (
    input  logic              mem_clk,
    input  logic              rst,
    input  logic              rd_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ready,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    output logic              wr_ready,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [2:0]        cmd_type,
    output logic [BG_W-1:0]   cmd_bg,
    output logic [BA_W-1:0]   cmd_ba,
    output logic [ROW_W-1:0]  cmd_row,
    output logic [COL_W-1:0]  cmd_col,
    output logic              data_en,
    output logic              data_sel,
    output logic              err_valid,
    output logic              err_rd,
    output logic [ADDR_W-1:0] err_addr,
    output logic              busy
);
    localparam int BK_W  = BG_W + BA_W;
    localparam int NB    = 1 << BK_W;
    localparam int CNT_W = 16;
    localparam int SW    = $clog2(STARVE_MAX + 1);

    localparam logic [2:0] C_NOP = 3'd0;
    localparam logic [2:0] C_ACT = 3'd1;
    localparam logic [2:0] C_RD  = 3'd2;
    localparam logic [2:0] C_WR  = 3'd3;
    localparam logic [2:0] C_PRE = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE, S_DECODE, S_PRE, S_WAIT_PRE, S_ACT,
        S_WAIT_ACT, S_RW, S_WAIT_CL, S_DATA
    } state_t;

    state_t            state, nxt;
    logic              ph;
    logic [ADDR_W-1:0] req_addr;
    logic              req_wr;
    logic              last_wr;
    logic [CNT_W-1:0]  cnt;
    logic [SW-1:0]     rd_byp, wr_byp;
    logic [NB-1:0]     open_q;
    logic [ROW_W-1:0]  row_q [NB];

    logic [BK_W-1:0]   rd_bk, wr_bk, q_bk;
    logic [ROW_W-1:0]  rd_row, wr_row, q_row;
    logic              rd_hit, wr_hit, q_hit, q_open;
    logic              legal, pick_wr, unused_addr;

    assign rd_bk  = rd_addr[COL_W +: BK_W];
    assign wr_bk  = wr_addr[COL_W +: BK_W];
    assign q_bk   = req_addr[COL_W +: BK_W];
    assign rd_row = rd_addr[COL_W+BK_W +: ROW_W];
    assign wr_row = wr_addr[COL_W+BK_W +: ROW_W];
    assign q_row  = req_addr[COL_W+BK_W +: ROW_W];
    assign unused_addr = ^{rd_addr, wr_addr};

    assign rd_hit = open_q[rd_bk] && (row_q[rd_bk] == rd_row);
    assign wr_hit = open_q[wr_bk] && (row_q[wr_bk] == wr_row);
    assign q_open = open_q[q_bk];
    assign q_hit  = q_open && (row_q[q_bk] == q_row);

    // Offset compare keeps the check unsigned and full width
    function automatic logic in_win(
        input logic [ADDR_W-1:0] a,
        input logic [ADDR_W-1:0] lo,
        input logic [ADDR_W-1:0] hi
    );
        return (a - lo) <= (hi - lo);
    endfunction

    assign legal = in_win(req_addr, R0_BASE, R0_LIMIT)
                || in_win(req_addr, R1_BASE, R1_LIMIT);

    always_comb begin
        pick_wr = 1'b0;
        if (!rd_valid)
            pick_wr = 1'b1;
        else if (!wr_valid)
            pick_wr = 1'b0;
        else if (rd_byp >= SW'(STARVE_MAX))
            pick_wr = 1'b0;
        else if (wr_byp >= SW'(STARVE_MAX))
            pick_wr = 1'b1;
        else if (rd_hit != wr_hit)
            pick_wr = wr_hit;
        else
            pick_wr = !last_wr;
    end

    always_comb begin
        nxt       = state;
        rd_ready  = 1'b0;
        wr_ready  = 1'b0;
        cmd_valid = 1'b0;
        cmd_type  = C_NOP;
        data_en   = 1'b0;
        data_sel  = 1'b0;
        err_valid = 1'b0;
        unique case (state)
            S_IDLE:
                if (rd_valid || wr_valid) nxt = S_DECODE;
            S_DECODE:
                if (!ph) begin
                    rd_ready = !req_wr;
                    wr_ready = req_wr;
                end else if (!legal) begin
                    err_valid = 1'b1;
                    nxt       = S_IDLE;
                end else if (q_hit) begin
                    nxt = S_RW;
                end else if (q_open) begin
                    nxt = S_PRE;
                end else begin
                    nxt = S_ACT;
                end
            S_PRE: begin
                cmd_valid = 1'b1;
                cmd_type  = C_PRE;
                if (cmd_ready) nxt = S_WAIT_PRE;
            end
            S_WAIT_PRE:
                if (cnt == '0) nxt = S_ACT;
            S_ACT: begin
                cmd_valid = 1'b1;
                cmd_type  = C_ACT;
                if (cmd_ready) nxt = S_WAIT_ACT;
            end
            S_WAIT_ACT:
                if (cnt == '0) nxt = S_RW;
            S_RW: begin
                cmd_valid = 1'b1;
                cmd_type  = req_wr ? C_WR : C_RD;
                if (cmd_ready) nxt = S_WAIT_CL;
            end
            S_WAIT_CL:
                if (cnt == '0) nxt = S_DATA;
            S_DATA: begin
                data_en  = 1'b1;
                data_sel = !req_wr;
                if (cnt == '0) nxt = S_IDLE;
            end
            default:
                nxt = S_IDLE;
        endcase
    end

    assign cmd_bg   = cmd_valid ? req_addr[COL_W+BA_W +: BG_W] : '0;
    assign cmd_ba   = cmd_valid ? req_addr[COL_W +: BA_W] : '0;
    assign cmd_row  = cmd_valid ? q_row : '0;
    assign cmd_col  = cmd_valid ? req_addr[COL_W-1:0] : '0;
    assign err_rd   = err_valid && !req_wr;
    assign err_addr = err_valid ? req_addr : '0;
    assign busy     = (state != S_IDLE);

    always_ff @(posedge mem_clk) begin
        if (rst) begin
            state    <= S_IDLE;
            ph       <= 1'b0;
            req_addr <= '0;
            req_wr   <= 1'b0;
            last_wr  <= 1'b0;
            cnt      <= '0;
            rd_byp   <= '0;
            wr_byp   <= '0;
            open_q   <= '0;
        end else begin
            state <= nxt;
            ph    <= (state == S_DECODE) && !ph;
            if (state == S_IDLE && (rd_valid || wr_valid)) begin
                req_addr <= pick_wr ? wr_addr : rd_addr;
                req_wr   <= pick_wr;
                last_wr  <= pick_wr;
                if (pick_wr) wr_byp <= '0;
                else         rd_byp <= '0;
                // Only a real contest counts as a bypass
                if (rd_valid && wr_valid) begin
                    if (pick_wr && rd_byp < SW'(STARVE_MAX))
                        rd_byp <= rd_byp + 1'b1;
                    if (!pick_wr && wr_byp < SW'(STARVE_MAX))
                        wr_byp <= wr_byp + 1'b1;
                end
            end
            if (state == S_PRE && cmd_ready)
                cnt <= CNT_W'(T_PRE - 1);
            else if (state == S_ACT && cmd_ready)
                cnt <= CNT_W'(T_ACT - 1);
            else if (state == S_RW && cmd_ready)
                cnt <= CNT_W'(CL - 2);
            else if (state == S_WAIT_CL && cnt == '0)
                cnt <= CNT_W'(BL - 1);
            else if (cnt != '0)
                cnt <= cnt - 1'b1;
            if (state == S_PRE && cmd_ready)
                open_q[q_bk] <= 1'b0;
            if (state == S_ACT && cmd_ready)
                open_q[q_bk] <= 1'b1;
        end
    end

    always_ff @(posedge mem_clk) begin
        if (state == S_ACT && cmd_ready)
            row_q[q_bk] <= q_row;
    end

endmodule

// File: doc/ddr_cmd_sched.md
# ddr_cmd_sched

Parametrised read/write command scheduler sitting between the address FIFOs and the packet generator / SerDes in the DDR5 controller, on the `mem_clk` domain. It pops read and write address requests, checks them against two programmable legal address windows, decodes them into bank group/bank/row/column, tracks the open row of every bank, and issues the PRE/ACT/RD/WR command sequence with tRP, tRCD and CL spacing. It replaces the fixed single-bank flow with:

- per-bank open-row tracking;
- row-hit-first arbitration with a starvation limit;
- in-line range error reporting.

## Interface
Parameters:
- `ADDR_W`, 32, request address width
- `COL_W`, 10, column bits, taken from addr[COL_W-1:0]
- `BA_W`, 2, bank bits, taken next above the column bits
- `BG_W`, 3, bank-group bits, taken next above the bank bits
- `ROW_W`, 16, row bits, taken next above the bank-group bits; any address bits above these are ignored
- `T_PRE`, 5, idle cycles after an accepted PRE
- `T_ACT`, 5, idle cycles after an accepted ACT
- `CL`, 20, cycles from an accepted RD/WR to the first data beat
- `BL`, 2, data beats per access
- `STARVE_MAX`, 8, maximum consecutive times one request type may be bypassed
- `R0_BASE`, 32'h0000_0000, window 0 lower bound, inclusive
- `R0_LIMIT`, 32'h0000_8000, window 0 upper bound, inclusive
- `R1_BASE`, 32'h0010_0000, window 1 lower bound, inclusive
- `R1_LIMIT`, 32'h0010_8000, window 1 upper bound, inclusive

Ports:
- `mem_clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `rd_valid`  in  1  read FIFO not empty
- `rd_addr`  in  ADDR_W  read FIFO head
- `rd_ready`  out  1  one-cycle pop strobe to the read FIFO
- `wr_valid`  in  1  write FIFO not empty
- `wr_addr`  in  ADDR_W  write FIFO head
- `wr_ready`  out  1  one-cycle pop strobe to the write FIFO
- `cmd_valid`  out  1  command present
- `cmd_ready`  in  1  packet generator accepts the command
- `cmd_type`  out  3  0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE
- `cmd_bg`  out  BG_W  command bank group
- `cmd_ba`  out  BA_W  command bank
- `cmd_row`  out  ROW_W  command row
- `cmd_col`  out  COL_W  command column
- `data_en`  out  1  SerDes enable, high during data beats
- `data_sel`  out  1  1 = read beat, 0 = write beat
- `err_valid`  out  1  one-cycle pulse for an out-of-window request
- `err_rd`  out  1  1 = the failing request was a read
- `err_addr`  out  ADDR_W  address of the failing request
- `busy`  out  1  high whenever the state is not IDLE

## Operation
- Bank table: 2^(BG_W+BA_W) entries, each holding {open, row}. Reset closes all entries.
- A request is legal if its address lies in [R0_BASE, R0_LIMIT] or in [R1_BASE, R1_LIMIT].
- Arbitration in IDLE:
  - Only one of rd_valid/wr_valid set: that type wins.
  - Both set: the type whose bank is open on a matching row wins.
  - Both hit, or both miss: the type not served last wins.
  - Override: if the other type has been bypassed STARVE_MAX times in a row, it wins.
- The winner is popped (its ready strobe is high for exactly one cycle) and latched, and the loser's bypass count increments.
- Illegal winner: err_valid, err_rd and err_addr are set for one cycle, no command is issued, and the state returns to IDLE.
- State flow: IDLE → DECODE → [PRE → WAIT_PRE] → [ACT → WAIT_ACT] → RW → WAIT_CL → DATA → IDLE.
  - Row hit: skip PRE and ACT.
  - Bank closed: skip PRE only.
  - Bank open on a different row: go through PRE.
- In PRE, ACT and RW, cmd_valid is held with stable fields until the cycle cmd_ready is high. The table updates on that accepting cycle: PRE closes the entry; ACT opens it with the new row.
- In DATA, data_en is high for BL cycles; data_sel is 1 for RD and 0 for WR.

## Timing
- Reset values: all outputs 0, cmd_type = NOP, state IDLE, bypass counters 0.
- rst asserted mid-sequence: within the next cycle, cmd_valid and data_en drop, the table clears and no pop occurs.
- Pop strobe: asserted in the cycle after IDLE sees a valid request.
- Row-hit latency: first RD/WR cmd_valid appears 2 cycles after the pop.
- Waits: WAIT_PRE lasts exactly T_PRE cycles after the PRE handshake; WAIT_ACT lasts exactly T_ACT cycles.
- Data: the first data_en beat is exactly CL cycles after the RD/WR handshake cycle.
- Back-to-back: the next IDLE decision happens in the cycle after the last data beat.
- A request arriving while busy is not popped.
- cmd_ready held low stalls the sequence indefinitely with no field change.
- Address arithmetic is unsigned, and the window compares are full ADDR_W wide.

## Test plan
- Reset, then a read of 0x0000_0400 into an empty table: sequence ACT (row 0, col 0x000, BG 0, BA 1), then RD. After the RD handshake, data_en rises 20 cycles later for 2 beats with data_sel = 1. Exactly one rd_ready pulse.
- A second read to the same row: no ACT is issued; RD appears 2 cycles after its pop.
- A read to the same bank but a different row: PRE, 5 idle cycles, ACT, 5 idle cycles, RD.
- wr_addr 0x0000_9000: err_valid = 1 and err_rd = 0 for one cycle, err_addr = 0x0000_9000, wr_ready pulses, no command. 0x0010_8000 is accepted.
- Reads continuously hitting an open row with a write missing pending: the write wins on the 9th decision.
- cmd_ready held low for 10 cycles during ACT: fields stay stable. Asserting rst mid-WAIT_CL: all outputs return to 0 the next cycle and the next same-row read requires an ACT.
